// File: rtl/calc_pkg.sv
// Shared constants for the calculator result path: status codes, range limits, FSM and glyph encodings.
// Pure declarations plus the double-dabble add-3 helper; no timing or flow control of its own.
package calc_pkg;

    localparam logic [31:0]        CALC_ERR_CODE  = 32'h00EE0000;
    localparam logic [31:0]        CALC_NULL_CODE = 32'h00CC0000;
    localparam logic signed [31:0] CALC_MIN       = -32'sd99999;
    localparam logic signed [31:0] CALC_MAX       = 32'sd999999;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_CHECK  = 2'd1;
    localparam state_t ST_CONV   = 2'd2;
    localparam state_t ST_FORMAT = 2'd3;

    localparam logic [1:0] CLS_NUM  = 2'd0;
    localparam logic [1:0] CLS_ERR  = 2'd1;
    localparam logic [1:0] CLS_NULL = 2'd2;

    localparam logic [2:0] GLY_DIGIT = 3'd0;
    localparam logic [2:0] GLY_MINUS = 3'd1;
    localparam logic [2:0] GLY_E     = 3'd2;
    localparam logic [2:0] GLY_R     = 3'd3;
    localparam logic [2:0] GLY_BLANK = 3'd4;

    function automatic logic [23:0] bcd_add3(input logic [23:0] b);
        logic [23:0] r;
        r = b;
        for (int k = 0; k < 6; k++) begin
            if (b[4*k +: 4] >= 4'd5) r[4*k +: 4] = b[4*k +: 4] + 4'd3;
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_encode.sv
// Glyph select + BCD digit -> one 7-segment pattern (g..a, MSB first), polarity set by SEG_ACTIVE_LOW.
// Purely combinational, zero latency, no flow control.
module seg7_encode
    import calc_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic [2:0] sel_i,
    input  logic [3:0] dig_i,
    output logic [6:0] seg_o
);

    logic [6:0] lit;

    always_comb begin
        lit = 7'h00;
        case (sel_i)
            GLY_DIGIT: begin
                case (dig_i)
                    4'd0:    lit = 7'h3F;
                    4'd1:    lit = 7'h06;
                    4'd2:    lit = 7'h5B;
                    4'd3:    lit = 7'h4F;
                    4'd4:    lit = 7'h66;
                    4'd5:    lit = 7'h6D;
                    4'd6:    lit = 7'h7D;
                    4'd7:    lit = 7'h07;
                    4'd8:    lit = 7'h7F;
                    4'd9:    lit = 7'h6F;
                    default: lit = 7'h00;
                endcase
            end
            GLY_MINUS: lit = 7'h40;
            GLY_E:     lit = 7'h79;
            GLY_R:     lit = 7'h50;
            default:   lit = 7'h00;
        endcase
        seg_o = SEG_ACTIVE_LOW ? ~lit : lit;
    end

endmodule

// File: rtl/calc_display.sv
// Captures a signed result, converts it via 20-cycle double-dabble and drives six 7-seg digits; done 22 edges after load.
// load is ignored while busy; define CALC_LEAD_ZERO_BLANK_EN to blank leading zeros (default shows them).
module calc_display
    import calc_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ans,
    input  logic        load,
    output logic        busy,
    output logic        done,
    output logic [41:0] hex_out
);

    state_t      state_q, state_d;
    logic [31:0] ans_q, ans_d;
    logic [1:0]  cls_q, cls_d;
    logic        neg_q, neg_d;
    logic [19:0] shift_q, shift_d;
    logic [23:0] bcd_q, bcd_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        done_q, done_d;
    logic [41:0] hex_q, hex_d;

    logic signed [31:0] ans_s;
    logic [19:0]        mag;
    logic [5:0][2:0]    sel;
    logic [5:0][3:0]    dig;
    logic [5:0][6:0]    seg;

    assign ans_s = ans_q;
    assign mag   = ans_q[31] ? 20'(-ans_q) : ans_q[19:0];

    always_comb begin
        state_d = state_q;
        ans_d   = ans_q;
        cls_d   = cls_q;
        neg_d   = neg_q;
        shift_d = shift_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        hex_d   = hex_q;
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    ans_d   = ans;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                // Error/null still run the full conversion on zero so latency never depends on the value.
                bcd_d   = '0;
                cnt_d   = '0;
                neg_d   = 1'b0;
                shift_d = '0;
                if (ans_q == CALC_NULL_CODE) begin
                    cls_d = CLS_NULL;
                end else if (ans_q == CALC_ERR_CODE || ans_s < CALC_MIN || ans_s > CALC_MAX) begin
                    cls_d = CLS_ERR;
                end else begin
                    cls_d   = CLS_NUM;
                    neg_d   = ans_q[31];
                    shift_d = mag;
                end
                state_d = ST_CONV;
            end
            ST_CONV: begin
                {bcd_d, shift_d} = {bcd_add3(bcd_q), shift_q} << 1;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd19) state_d = ST_FORMAT;
            end
            default: begin
                hex_d   = seg;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef CALC_LEAD_ZERO_BLANK_EN
    int msd;
`endif

    always_comb begin
        for (int k = 0; k < 6; k++) begin
            sel[k] = GLY_BLANK;
            dig[k] = bcd_q[4*k +: 4];
        end
`ifdef CALC_LEAD_ZERO_BLANK_EN
        msd = 0;
        for (int k = 1; k < 6; k++) begin
            if (bcd_q[4*k +: 4] != 4'd0) msd = k;
        end
`endif
        case (cls_q)
            CLS_ERR: begin
                sel[2] = GLY_E;
                sel[1] = GLY_R;
                sel[0] = GLY_R;
            end
            CLS_NULL: begin
                for (int k = 0; k < 6; k++) sel[k] = GLY_MINUS;
            end
            default: begin
`ifdef CALC_LEAD_ZERO_BLANK_EN
                for (int k = 0; k < 6; k++) begin
                    if (k <= msd) sel[k] = GLY_DIGIT;
                    else if (neg_q && k == msd + 1) sel[k] = GLY_MINUS;
                end
`else
                for (int k = 0; k < 6; k++) sel[k] = GLY_DIGIT;
                // Negative magnitudes never exceed 99999, so digit 5 is always a free zero.
                if (neg_q) sel[5] = GLY_MINUS;
`endif
            end
        endcase
    end

    for (genvar k = 0; k < 6; k++) begin : g_seg
        seg7_encode #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg (
            .sel_i (sel[k]),
            .dig_i (dig[k]),
            .seg_o (seg[k])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            ans_q   <= '0;
            cls_q   <= CLS_NUM;
            neg_q   <= 1'b0;
            shift_q <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            hex_q   <= {42{SEG_ACTIVE_LOW}};
        end else begin
            state_q <= state_d;
            ans_q   <= ans_d;
            cls_q   <= cls_d;
            neg_q   <= neg_d;
            shift_q <= shift_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            hex_q   <= hex_d;
        end
    end

    assign busy    = (state_q != ST_IDLE);
    assign done    = done_q;
    assign hex_out = hex_q;

endmodule

// File: tb/tb_calc_display.sv
// Self-checking bench for calc_display: directed vector table, busy/reset corner sequences, random values vs a reference model.
// Expected displays are six-character strings turned into segment patterns by the bench.
module tb_calc_display;

    localparam bit SEG_ACTIVE_LOW = 1'b1;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ans;
    logic        load;
    logic        busy;
    logic        done;
    logic [41:0] hex_out;

    int errors = 0;
    int checks = 0;
    logic [41:0] cur_hex;
    int dcnt;
    int extra;
    logic [47:0] e;
    logic [31:0] rv;

    typedef struct {
        logic [31:0] a;
        logic [47:0] lz;
        logic [47:0] nz;
    } vec_t;
    vec_t vecs[13];

    calc_display #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) dut (
        .clk     (clk),
        .rst     (rst),
        .ans     (ans),
        .load    (load),
        .busy    (busy),
        .done    (done),
        .hex_out (hex_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [7:0] c);
        logic [6:0] g;
        case (c)
            "0": g = 7'b0111111;
            "1": g = 7'b0000110;
            "2": g = 7'b1011011;
            "3": g = 7'b1001111;
            "4": g = 7'b1100110;
            "5": g = 7'b1101101;
            "6": g = 7'b1111101;
            "7": g = 7'b0000111;
            "8": g = 7'b1111111;
            "9": g = 7'b1101111;
            "-": g = 7'b1000000;
            "E": g = 7'b1111001;
            "r": g = 7'b1010000;
            default: g = 7'b0000000;
        endcase
        return SEG_ACTIVE_LOW ? ~g : g;
    endfunction

    function automatic logic [41:0] str2hex(input logic [47:0] s);
        logic [41:0] h;
        for (int k = 0; k < 6; k++) h[7*k +: 7] = glyph(s[8*k +: 8]);
        return h;
    endfunction

    // Reference: render the value as text the way a person would read the display.
    function automatic logic [47:0] model_str(input logic [31:0] a);
        int v;
        int m;
        int d[6];
        int top;
        bit neg;
        logic [47:0] s;
        v = a;
        if (a == 32'h00CC0000) return "------";
        if (a == 32'h00EE0000 || v < -99999 || v > 999999) return "   Err";
        neg = (v < 0);
        m = neg ? -v : v;
        for (int k = 0; k < 6; k++) begin
            d[k] = m % 10;
            m = m / 10;
        end
        s = {6{8'h20}};
`ifdef CALC_LEAD_ZERO_BLANK_EN
        top = 0;
        for (int k = 1; k < 6; k++) if (d[k] != 0) top = k;
        for (int k = 0; k < 6; k++) begin
            if (k <= top) s[8*k +: 8] = 8'h30 + 8'(d[k]);
            else if (neg && k == top + 1) s[8*k +: 8] = "-";
        end
`else
        top = 0;
        for (int k = 0; k < 6; k++) s[8*k +: 8] = 8'h30 + 8'(d[k] + top);
        if (neg) s[47:40] = "-";
`endif
        return s;
    endfunction

    function automatic logic [47:0] pick(input logic [47:0] lz, input logic [47:0] nz);
`ifdef CALC_LEAD_ZERO_BLANK_EN
        return (nz == nz) ? lz : nz;
`else
        return (lz == lz) ? nz : lz;
`endif
    endfunction

    // One transaction; inj_n >= 0 pulses load (ans=5) at that cycle while busy.
    task automatic run_xact(input logic [31:0] a, input logic [47:0] exp_s, input string name, input int inj_n);
        logic [41:0] exp_hex;
        int lat;
        int bcnt;
        bit changed;
        lat = -1;
        bcnt = 0;
        changed = 1'b0;
        exp_hex = str2hex(exp_s);
        @(negedge clk);
        ans  = a;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        ans  = $urandom;
        for (int n = 0; n < 40; n++) begin
            if (done) begin
                lat = n;
                break;
            end
            if (busy) bcnt++;
            if (hex_out !== cur_hex) changed = 1'b1;
            if (n == inj_n) begin
                ans  = 32'd5;
                load = 1'b1;
            end else begin
                load = 1'b0;
            end
            @(negedge clk);
        end
        load = 1'b0;
        chk({name, " latency"}, 64'(lat), 64'd22);
        chk({name, " busy_cycles"}, 64'(bcnt), 64'd22);
        chk({name, " busy_at_done"}, 64'(busy), 64'd0);
        chk({name, " hex"}, 64'(hex_out), 64'(exp_hex));
        chk({name, " hex_hold"}, 64'(changed), 64'd0);
        @(negedge clk);
        chk({name, " done_width"}, 64'(done), 64'd0);
        cur_hex = exp_hex;
    endtask

    initial begin
        vecs[0]  = '{32'd12345,      " 12345", "012345"};
        vecs[1]  = '{-32'sd42,       "   -42", "-00042"};
        vecs[2]  = '{32'd0,          "     0", "000000"};
        vecs[3]  = '{32'h00EE0000,   "   Err", "   Err"};
        vecs[4]  = '{32'd1000000,    "   Err", "   Err"};
        vecs[5]  = '{32'h00CC0000,   "------", "------"};
        vecs[6]  = '{32'd999999,     "999999", "999999"};
        vecs[7]  = '{-32'sd99999,    "-99999", "-99999"};
        vecs[8]  = '{32'd42,         "    42", "000042"};
        vecs[9]  = '{-32'sd100000,   "   Err", "   Err"};
        vecs[10] = '{-32'sd1,        "    -1", "-00001"};
        vecs[11] = '{32'd100000,     "100000", "100000"};
        vecs[12] = '{-32'sd9,        "    -9", "-00009"};

        rst  = 1'b0;
        ans  = '0;
        load = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset hex", 64'(hex_out), 64'(str2hex("      ")));
        rst = 1'b1;
        cur_hex = str2hex("      ");

        for (int i = 0; i < 13; i++) begin
            e = pick(vecs[i].lz, vecs[i].nz);
            run_xact(vecs[i].a, e, $sformatf("vec%0d", i), -1);
        end

        // load arriving mid-conversion must neither alter the value nor start a second run
        run_xact(32'd777, pick("   777", "000777"), "busyload", 3);
        extra = 0;
        repeat (25) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        chk("busyload no_second_run", 64'(extra), 64'd0);

        // reset in the middle of a conversion
        @(negedge clk);
        ans  = 32'd12345;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst busy", 64'(busy), 64'd0);
        chk("midrst done", 64'(done), 64'd0);
        chk("midrst hex", 64'(hex_out), 64'(str2hex("      ")));
        dcnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        rst = 1'b1;
        repeat (25) begin
            @(negedge clk);
            if (done || busy) dcnt++;
        end
        chk("midrst no_done", 64'(dcnt), 64'd0);
        cur_hex = str2hex("      ");
        run_xact(32'd8, pick("     8", "000008"), "after_rst", -1);

        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 4))
                0: rv = 32'($urandom_range(0, 999999));
                1: rv = -32'($urandom_range(1, 99999));
                2: rv = $urandom;
                3: rv = -32'($urandom_range(1, 999));
                default: rv = 32'($urandom_range(0, 99));
            endcase
            run_xact(rv, model_str(rv), $sformatf("rand%0d", i), -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
